// File: rtl/bin_display7_driver.sv
// Binary-to-7-segment display driver with a sequential double-dabble engine.
// Converts a signed or unsigned value to decimal one bit per cycle. The
// displays, overflow flag and sign update together once per conversion.
module bin_display7_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int SIGNED     = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   value,
    output logic [7*NUM_DIGITS-1:0] digits,
    output logic [6:0]              sign_seg,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    // Enough BCD digits for any DATA_WIDTH-bit magnitude. The register is
    // widened to NUM_DIGITS when more displays exist than the value can fill,
    // so every display has a digit to read (the extra digits stay zero).
    localparam int BCD_INT = DATA_WIDTH / 3 + 1;
    localparam int BCD_N   = (BCD_INT > NUM_DIGITS) ? BCD_INT : NUM_DIGITS;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    neg_q, neg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [6:0]              sign_seg_q, sign_seg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;

    logic [BCD_W-1:0]        adj;
    logic [7*NUM_DIGITS-1:0] disp_digits;
    logic [6:0]              disp_sign;
    logic                    disp_ovf;
    logic                    seen;

    // Active-low g..a pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: IDLE -> CONVERT for DATA_WIDTH cycles -> UPDATE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_UPDATE;
            S_UPDATE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Display image built from the finished BCD register: overflow detect,
    // leading-zero blanking and sign selection.
    always_comb begin
        disp_ovf    = 1'b0;
        seen        = 1'b0;
        disp_digits = '1;
        disp_sign   = neg_q ? SEG_MINUS : SEG_BLANK;
        for (int k = NUM_DIGITS; k < BCD_N; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) disp_ovf = 1'b1;
        end
        // Scan from the top; digit0 always counts as significant so zero shows "0".
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen = seen | (bcd_q[4*k +: 4] != 4'd0) | (k == 0);
            disp_digits[7*k +: 7] = ((LZ_BLANK != 0) && !seen) ? SEG_BLANK
                                                                : seg7(bcd_q[4*k +: 4]);
        end
        if (disp_ovf) begin
            disp_digits      = '1;
            disp_digits[6:0] = SEG_E;
            disp_sign        = SEG_BLANK;
        end
    end

    // Datapath next values: capture, shift-add-3 iteration, display load.
    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        digits_d   = digits_q;
        sign_seg_d = sign_seg_q;
        overflow_d = overflow_q;
        adj        = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d  = (SIGNED != 0) && value[DATA_WIDTH-1];
                    // Negation of the sign-extended value in DATA_WIDTH+1 bits;
                    // the top bit of the result is always zero, so the low
                    // DATA_WIDTH bits hold the exact magnitude, most negative included.
                    bin_d  = neg_d ? DATA_WIDTH'(-{1'b1, value}) : value;
                    bcd_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_CONVERT: begin
                for (int i = 0; i < BCD_N; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
            end
            S_UPDATE: begin
                digits_d   = disp_digits;
                sign_seg_d = disp_sign;
                overflow_d = disp_ovf;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and display registers; reset blanks every display.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '1;
            sign_seg_q <= SEG_BLANK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            sign_seg_q <= sign_seg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        digits   = digits_q;
        sign_seg = sign_seg_q;
        busy     = busy_q;
        done     = done_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_bin_display7_driver.sv
// Scoreboard bench: four driver instances (default, no blanking, 3 digits,
// unsigned). Stimulus pushes expected displays; a monitor pops on each done.
module tb_bin_display7_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SM = 7'b0111111, SE = 7'b0000110,
                           SB = 7'b1111111;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       start = '0;
    logic [3:0][15:0] val   = '0;
    logic [34:0]      dig0, dig1, dig3;
    logic [20:0]      dig2;
    logic [3:0][6:0]  sg;
    logic [3:0]       busy, done, ovf;

    always #5 clock = ~clock;

    bin_display7_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .SIGNED(1), .LZ_BLANK(1)) u0 (
        .clock(clock), .reset(reset), .start(start[0]), .value(val[0]), .digits(dig0),
        .sign_seg(sg[0]), .busy(busy[0]), .done(done[0]), .overflow(ovf[0]));
    bin_display7_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .SIGNED(1), .LZ_BLANK(0)) u1 (
        .clock(clock), .reset(reset), .start(start[1]), .value(val[1]), .digits(dig1),
        .sign_seg(sg[1]), .busy(busy[1]), .done(done[1]), .overflow(ovf[1]));
    bin_display7_driver #(.DATA_WIDTH(16), .NUM_DIGITS(3), .SIGNED(1), .LZ_BLANK(1)) u2 (
        .clock(clock), .reset(reset), .start(start[2]), .value(val[2]), .digits(dig2),
        .sign_seg(sg[2]), .busy(busy[2]), .done(done[2]), .overflow(ovf[2]));
    bin_display7_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .SIGNED(0), .LZ_BLANK(1)) u3 (
        .clock(clock), .reset(reset), .start(start[3]), .value(val[3]), .digits(dig3),
        .sign_seg(sg[3]), .busy(busy[3]), .done(done[3]), .overflow(ovf[3]));

    typedef struct {
        int          id;
        logic [34:0] dig;
        logic [6:0]  sgn;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (|done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done got=%b want=0000 (cycle %0d)", done, cyc);
            end else begin
                exp_t        e;
                logic [34:0] gd;
                e = sb.pop_front();
                case (e.id)
                    0:       gd = dig0;
                    1:       gd = dig1;
                    2:       gd = {14'd0, dig2};
                    default: gd = dig3;
                endcase
                chk("done_instance", 64'(done), 64'(4'b0001 << e.id));
                chk("latency_cycle", 64'(cyc), 64'(e.due));
                chk("digits", 64'(gd), 64'(e.dig));
                chk("sign_seg", 64'(sg[e.id]), 64'(e.sgn));
                chk("overflow", 64'(ovf[e.id]), 64'(e.ovf));
                chk("busy_clear", 64'(busy[e.id]), 64'd0);
            end
        end
    end

    // Issue start at a negedge; the following posedge is the start edge.
    task automatic issue(input int id, input logic [15:0] v, input logic [34:0] d,
                         input logic [6:0] s, input logic o);
        @(negedge clock);
        start[id] = 1'b1;
        val[id]   = v;
        sb.push_back('{id, d, s, o, cyc + 1 + 17});
        @(negedge clock);
        start[id] = 1'b0;
        chk("busy_set", 64'(busy[id]), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=%0d_pending want=0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic conv(input int id, input logic [15:0] v, input logic [34:0] d,
                        input logic [6:0] s, input logic o);
        issue(id, v, d, s, o);
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_digits", 64'(dig0), {29'd0, {35{1'b1}}});
        chk("rst_sign", 64'(sg[0]), 64'(SB));
        chk("rst_flags", 64'({busy, done, ovf}), 64'd0);
        reset = 1'b0;

        conv(0, 16'd1234,  {SB, S1, S2, S3, S4}, SB, 1'b0);
        conv(0, 16'h8000,  {S3, S2, S7, S6, S8}, SM, 1'b0);
        conv(0, 16'd0,     {SB, SB, SB, SB, S0}, SB, 1'b0);
        conv(1, 16'd0,     {S0, S0, S0, S0, S0}, SB, 1'b0);
        conv(1, 16'd42,    {S0, S0, S0, S4, S2}, SB, 1'b0);
        conv(0, 16'hFFFB,  {SB, SB, SB, SB, S5}, SM, 1'b0);
        conv(0, 16'd10000, {S1, S0, S0, S0, S0}, SB, 1'b0);
        conv(0, 16'h7FFF,  {S3, S2, S7, S6, S7}, SB, 1'b0);
        conv(2, 16'd1000,  {SB, SB, SE}, SB, 1'b1);
        conv(2, 16'd999,   {S9, S9, S9}, SB, 1'b0);
        conv(2, 16'hFC18,  {SB, SB, SE}, SB, 1'b1);
        conv(2, 16'hFC19,  {S9, S9, S9}, SM, 1'b0);

        // start and value changes during a conversion must be ignored
        issue(3, 16'hFFFF, {S6, S5, S5, S3, S5}, SB, 1'b0);
        val[3] = 16'd1;
        repeat (3) @(negedge clock);
        start[3] = 1'b1;
        @(negedge clock);
        start[3] = 1'b0;
        chk("busy_hold", 64'(busy[3]), 64'd1);
        drain();
        repeat (25) @(negedge clock);
        conv(3, 16'h8000,  {S3, S2, S7, S6, S8}, SB, 1'b0);

        // asynchronous reset in the middle of a conversion: no expectation pushed
        @(negedge clock);
        start[0] = 1'b1;
        val[0]   = 16'd12345;
        @(negedge clock);
        start[0] = 1'b0;
        repeat (7) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digits", 64'(dig0), {29'd0, {35{1'b1}}});
        chk("async_rst_sign", 64'(sg[0]), 64'(SB));
        chk("async_rst_busy", 64'(busy[0]), 64'd0);
        chk("async_rst_ovf", 64'({done[0], ovf[0]}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        conv(0, 16'd77,    {SB, SB, SB, S7, S7}, SB, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
